// File: rtl/dct_pkg.sv
// dct_pkg: shared DCT geometry and coefficient slice helper for the row, transpose and column stages
package dct_pkg;
    localparam int N = 8;
    localparam int W = 22;
    // lowest bit of element k in a packed vector of w-bit coefficients
    function automatic int slice_lo(input int k, input int w);
        return k * w;
    endfunction
endpackage

// File: rtl/transpose_bank.sv
// transpose_bank: one NxN coefficient store with a row write port and a column read mux
//   clk      - write clock
//   we_i     - write row_i into row wr_row_i
//   wr_row_i - row index written
//   row_i    - N packed W-bit coefficients, element k at slice k
//   rd_col_i - column index read
//   col_o    - column rd_col_i, row element r at slice r
module transpose_bank
    import dct_pkg::*;
#(
    parameter int N = dct_pkg::N,
    parameter int W = dct_pkg::W
) (
    input  logic                 clk,
    input  logic                 we_i,
    input  logic [$clog2(N)-1:0] wr_row_i,
    input  logic [N*W-1:0]       row_i,
    input  logic [$clog2(N)-1:0] rd_col_i,
    output logic [N*W-1:0]       col_o
);
    // storage is intentionally not reset; validity lives in the FULL flags
    logic [W-1:0] mem_q [N][N];

    always_ff @(posedge clk) begin
        if (we_i)
            for (int k = 0; k < N; k++)
                mem_q[wr_row_i][k] <= row_i[slice_lo(k, W) +: W];
    end

    always_comb begin
        col_o = '0;
        for (int r = 0; r < N; r++)
            col_o[slice_lo(r, W) +: W] = mem_q[r][rd_col_i];
    end
endmodule

// File: rtl/dct_transpose_buffer.sv
// dct_transpose_buffer: ping-pong NxN transpose between the row and column DCT stages
//   clk       - clock
//   reset     - asynchronous active-low reset
//   in_valid  - in_row holds a row-DCT result
//   in_row    - N packed W-bit coefficients, element k at slice k
//   in_ready  - row accepted this cycle when in_valid is high
//   out_valid - out_col holds a column
//   out_col   - N packed W-bit coefficients, row element r at slice r
//   out_ready - column stage accepts out_col
//   out_last  - out_col is column N-1 of its block
module dct_transpose_buffer
    import dct_pkg::*;
#(
    parameter int N = dct_pkg::N,
    parameter int W = dct_pkg::W
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           in_valid,
    input  logic [N*W-1:0] in_row,
    output logic           in_ready,
    output logic           out_valid,
    output logic [N*W-1:0] out_col,
    input  logic           out_ready,
    output logic           out_last
);
    localparam int AW = $clog2(N);
    localparam logic [AW-1:0] LAST = AW'(N - 1);

    logic          wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
    logic [AW-1:0] wr_row_q, wr_row_d, rd_col_q, rd_col_d;
    logic [1:0]    full_q, full_d;
    logic          acc, xfer, wlast, rlast;
    logic [N*W-1:0] col0, col1;

    always_comb begin
        in_ready  = !full_q[wr_bank_q];
        out_valid = full_q[rd_bank_q];
        out_last  = out_valid && rd_col_q == LAST;
        acc       = in_valid && in_ready;
        xfer      = out_valid && out_ready;
        wlast     = acc && wr_row_q == LAST;
        rlast     = xfer && rd_col_q == LAST;
        wr_row_d  = wlast ? '0 : acc ? wr_row_q + 1'b1 : wr_row_q;
        rd_col_d  = rlast ? '0 : xfer ? rd_col_q + 1'b1 : rd_col_q;
        wr_bank_d = wr_bank_q ^ wlast;
        rd_bank_d = rd_bank_q ^ rlast;
        // a finishing write needs an empty bank and a finishing read a full one,
        // so simultaneous updates always target different flags
        full_d = full_q;
        if (rlast)
            full_d[rd_bank_q] = 1'b0;
        if (wlast)
            full_d[wr_bank_q] = 1'b1;
        out_col = rd_bank_q ? col1 : col0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            wr_row_q  <= '0;
            rd_col_q  <= '0;
            full_q    <= '0;
        end else begin
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            wr_row_q  <= wr_row_d;
            rd_col_q  <= rd_col_d;
            full_q    <= full_d;
        end
    end

    transpose_bank #(.N(N), .W(W)) u_bank0 (
        .clk      (clk),
        .we_i     (acc && !wr_bank_q),
        .wr_row_i (wr_row_q),
        .row_i    (in_row),
        .rd_col_i (rd_col_q),
        .col_o    (col0)
    );

    transpose_bank #(.N(N), .W(W)) u_bank1 (
        .clk      (clk),
        .we_i     (acc && wr_bank_q),
        .wr_row_i (wr_row_q),
        .row_i    (in_row),
        .rd_col_i (rd_col_q),
        .col_o    (col1)
    );
endmodule

// File: tb/tb_dct_transpose_buffer.sv
// tb_dct_transpose_buffer: directed checks of ping-pong transpose streaming, backpressure, signs and reset
module tb_dct_transpose_buffer;
    import dct_pkg::*;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic           in_valid = 1'b0;
    logic [N*W-1:0] in_row = '0;
    logic           in_ready;
    logic           out_valid;
    logic [N*W-1:0] out_col;
    logic           out_ready = 1'b0;
    logic           out_last;
    int             pass_cnt = 0;
    int             tot_cnt = 0;

    dct_transpose_buffer #(.N(N), .W(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_row    (in_row),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_col   (out_col),
        .out_ready (out_ready),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [N*W-1:0] got, input logic [N*W-1:0] exp);
        tot_cnt++;
        if (got !== exp)
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        else
            pass_cnt++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // block b, row r: element k = 64b + 8r + k
    function automatic logic [N*W-1:0] row_val(input int b, input int r);
        logic [N*W-1:0] v = '0;
        for (int k = 0; k < N; k++)
            v[k*W +: W] = W'(64*b + 8*r + k);
        return v;
    endfunction

    // block b, column c: element r = 64b + 8r + c
    function automatic logic [N*W-1:0] col_val(input int b, input int c);
        logic [N*W-1:0] v = '0;
        for (int r = 0; r < N; r++)
            v[r*W +: W] = W'(64*b + 8*r + c);
        return v;
    endfunction

    function automatic logic [W-1:0] sgn(input int k);
        return (k % 2) ? 22'h1FFFFF : 22'h200000;
    endfunction

    task automatic write_block(input int b);
        for (int r = 0; r < N; r++) begin
            in_valid = 1'b1;
            in_row = row_val(b, r);
            chk("in_ready_wr", in_ready, 1'b1);
            step();
        end
        in_valid = 1'b0;
    endtask

    initial begin
        logic [N*W-1:0] srow;
        logic [N*W-1:0] scol;
        step();
        step();
        reset = 1'b1;
        #1;
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_last", out_last, 1'b0);

        // stream: one block, columns start right after row N-1
        out_ready = 1'b1;
        for (int r = 0; r < N; r++) begin
            in_valid = 1'b1;
            in_row = row_val(0, r);
            chk("stream_ov_pre", out_valid, 1'b0);
            step();
        end
        in_valid = 1'b0;
        for (int c = 0; c < N; c++) begin
            chk("stream_ov", out_valid, 1'b1);
            chk("stream_col", out_col, col_val(0, c));
            chk("stream_last", out_last, c == N - 1);
            step();
        end
        chk("stream_ov_end", out_valid, 1'b0);

        // back-to-back: four blocks, no bubbles on either side
        for (int t = 0; t < 40; t++) begin
            in_valid = t < 32;
            in_row = row_val(1 + t / 8, t % 8);
            if (t < 32)
                chk("b2b_in_ready", in_ready, 1'b1);
            chk("b2b_ov", out_valid, t >= 8);
            if (t >= 8) begin
                chk("b2b_col", out_col, col_val(1 + (t - 8) / 8, (t - 8) % 8));
                chk("b2b_last", out_last, (t - 8) % 8 == 7);
            end
            step();
        end
        in_valid = 1'b0;
        chk("b2b_ov_end", out_valid, 1'b0);

        // backpressure: both banks fill, extra row ignored, first block intact
        out_ready = 1'b0;
        write_block(5);
        write_block(6);
        in_valid = 1'b1;
        in_row = row_val(15, 0);
        chk("bp_in_ready_low", in_ready, 1'b0);
        chk("bp_ov", out_valid, 1'b1);
        step();
        in_valid = 1'b0;
        chk("bp_in_ready_low2", in_ready, 1'b0);
        chk("bp_hold_col", out_col, col_val(5, 0));
        out_ready = 1'b1;
        for (int i = 0; i < 2 * N; i++) begin
            chk("bp_ov_rd", out_valid, 1'b1);
            chk("bp_col", out_col, col_val(5 + i / 8, i % 8));
            step();
        end
        chk("bp_ov_end", out_valid, 1'b0);

        // stall: out_ready toggles, every column held until taken
        out_ready = 1'b0;
        write_block(7);
        for (int i = 0; i < 2 * N; i++) begin
            out_ready = i[0];
            chk("stall_ov", out_valid, 1'b1);
            chk("stall_col", out_col, col_val(7, i / 2));
            step();
        end
        out_ready = 1'b1;
        chk("stall_ov_end", out_valid, 1'b0);

        // sign extremes pass bit-exact; column c carries sgn(c) in every lane
        srow = '0;
        for (int k = 0; k < N; k++)
            srow[k*W +: W] = sgn(k);
        for (int r = 0; r < N; r++) begin
            in_valid = 1'b1;
            in_row = srow;
            step();
        end
        in_valid = 1'b0;
        for (int c = 0; c < N; c++) begin
            scol = '0;
            for (int r = 0; r < N; r++)
                scol[r*W +: W] = sgn(c);
            chk("sign_col", out_col, scol);
            step();
        end

        // reset mid-block discards the partial block
        for (int r = 0; r < 5; r++) begin
            in_valid = 1'b1;
            in_row = row_val(8, r);
            step();
        end
        in_valid = 1'b0;
        reset = 1'b0;
        #1;
        chk("midrst_ov", out_valid, 1'b0);
        chk("midrst_in_ready", in_ready, 1'b1);
        step();
        reset = 1'b1;
        #1;
        for (int r = 0; r < N; r++) begin
            in_valid = 1'b1;
            in_row = row_val(9, r);
            chk("post_rst_ov_pre", out_valid, 1'b0);
            step();
        end
        in_valid = 1'b0;
        for (int c = 0; c < N; c++) begin
            chk("post_rst_col", out_col, col_val(9, c));
            chk("post_rst_last", out_last, c == N - 1);
            step();
        end
        chk("post_rst_ov_end", out_valid, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end
endmodule
